contact_mem_ctrl: RTL and testbench

- Sequences the 7-word contact-record RAM used by the sphere-collision pipeline. Arbitrates up to NUM_REQ collision units that each deliver one 7-word contact record. Each granted record is written in a single RAM write cycle at the next free record slot.
- On command, drains the stored words one per cycle to the downstream consumer, then empties the buffer. Sits between the collider engines and the 7-input / 1-output contact RAM. Owns all RAM control: cs, we, oe, addressin, addressout, datain0..6.

---
 rtl/contact_mem_pkg.sv | 8 +
 rtl/contact_mem_ctrl_rr_arbiter.sv | 22 ++
 rtl/contact_mem_ctrl.sv | 101 ++++++++++
 tb/tb_contact_mem_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/contact_mem_pkg.sv
// contact_mem_pkg: shared record geometry, controller states and sizing helper
package contact_mem_pkg;
  localparam int REC_WORDS = 7;
  typedef enum logic [1:0] {IDLE, WRITE, DRAIN, FLUSH} state_t;
  function automatic int max_records(input int depth);
    return depth / REC_WORDS;
  endfunction
endpackage

// File: rtl/contact_mem_ctrl_rr_arbiter.sv
// rr_arbiter: N-way round-robin arbiter, search starts at ptr
// Ports: req (request vector), ptr (highest-priority index), grant (one-hot or zero), winner (index of granted requester)
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] winner
);
  // Walk from the farthest offset back to ptr so the nearest requester is the last one written.
  always_comb begin
    grant  = '0;
    winner = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req[(int'(ptr) + i) % N]) begin
        grant  = N'(1) << ((int'(ptr) + i) % N);
        winner = IW'((int'(ptr) + i) % N);
      end
  end
endmodule

// File: rtl/contact_mem_ctrl.sv
// contact_mem_ctrl: arbitrates 7-word contact records into the contact RAM and drains them on command
// Ports: clk/rst_n (async active-low); req_valid/req_ready/req_data (per-requester records);
//        drain_start (readout pulse); ram_* (RAM control, addresses, write words, read data);
//        out_valid/out_data/out_index (drained stream); rec_count/full/busy/drain_done (status)
module contact_mem_ctrl
  import contact_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int RAM_DEPTH  = 32,
  parameter int NUM_REQ    = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic [NUM_REQ*REC_WORDS*DATA_WIDTH-1:0] req_data,
  input  logic                                drain_start,
  output logic                                ram_cs,
  output logic                                ram_we,
  output logic                                ram_oe,
  output logic [ADDR_WIDTH-1:0]               ram_addr_in,
  output logic [ADDR_WIDTH-1:0]               ram_addr_out,
  output logic [REC_WORDS*DATA_WIDTH-1:0]     ram_din,
  input  logic [DATA_WIDTH-1:0]               ram_dout,
  output logic                                out_valid,
  output logic [DATA_WIDTH-1:0]               out_data,
  output logic [ADDR_WIDTH-1:0]               out_index,
  output logic [3:0]                          rec_count,
  output logic                                full,
  output logic                                busy,
  output logic                                drain_done
);
  localparam int PW = $clog2(RAM_DEPTH + 1);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int RW = REC_WORDS * DATA_WIDTH;
  state_t state, nxt;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [IW-1:0] rr_ptr, winner;
  logic [NUM_REQ-1:0] grant;
  logic go_write, go_drain, go_empty, last_rd;
  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
    .req(req_valid),
    .ptr(rr_ptr),
    .grant(grant),
    .winner(winner)
  );
  always_comb begin
    full         = int'(wr_ptr) + REC_WORDS > RAM_DEPTH;
    go_drain     = state == IDLE && drain_start && rec_count != '0;
    go_empty     = state == IDLE && drain_start && rec_count == '0;
    go_write     = state == IDLE && !drain_start && |req_valid && !full;
    last_rd      = rd_ptr == wr_ptr - PW'(1);
    nxt          = go_drain ? DRAIN :
                   go_write ? WRITE :
                   (state == DRAIN && last_rd) ? FLUSH :
                   (state == WRITE || state == FLUSH) ? IDLE : state;
    req_ready    = go_write ? grant : '0;
    busy         = state == DRAIN || state == FLUSH;
    ram_cs       = state == WRITE || state == DRAIN;
    ram_we       = state == WRITE;
    ram_oe       = state == DRAIN;
    ram_addr_out = ADDR_WIDTH'(rd_ptr);
    // RAM read data is already registered, so the word is forwarded in the cycle out_valid is high.
    out_data     = out_valid ? ram_dout : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      rr_ptr      <= '0;
      rec_count   <= '0;
      ram_din     <= '0;
      ram_addr_in <= '0;
      out_valid   <= 1'b0;
      out_index   <= '0;
      drain_done  <= 1'b0;
    end else begin
      state      <= nxt;
      drain_done <= go_empty || state == FLUSH;
      out_valid  <= state == DRAIN;
      out_index  <= state == DRAIN ? ADDR_WIDTH'(rd_ptr) : '0;
      if (go_write) begin
        ram_din     <= req_data[int'(winner)*RW +: RW];
        ram_addr_in <= ADDR_WIDTH'(wr_ptr);
        rr_ptr      <= (int'(winner) == NUM_REQ - 1) ? '0 : winner + IW'(1);
      end
      if (state == WRITE) begin
        wr_ptr    <= wr_ptr + PW'(REC_WORDS);
        rec_count <= rec_count + 4'd1;
      end
      if (state == DRAIN) rd_ptr <= rd_ptr + PW'(1);
      if (state == FLUSH) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        rec_count <= '0;
      end
    end
  end
endmodule

// File: tb/tb_contact_mem_ctrl.sv
// tb_contact_mem_ctrl: scoreboard bench with a behavioural RAM and record-level reference model
module tb_contact_mem_ctrl;
  import contact_mem_pkg::*;
  localparam int DW = 32, AW = 32, DEPTH = 32, N = 2, RW = REC_WORDS * DW;
  localparam int MAXR = max_records(DEPTH);
  typedef struct { logic [31:0] idx; logic [DW-1:0] data; } ow_t;
  typedef struct { logic [31:0] addr; logic [RW-1:0] din; } wr_t;
  logic clk = 0, rst_n = 0, drain_start = 0;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [N*RW-1:0] req_data = '0;
  logic ram_cs, ram_we, ram_oe, out_valid, full, busy, drain_done;
  logic [AW-1:0] ram_addr_in, ram_addr_out, out_index;
  logic [RW-1:0] ram_din;
  logic [DW-1:0] ram_dout = '0, out_data;
  logic [3:0] rec_count;
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] store[$];
  ow_t oq[$];
  wr_t wq[$];
  ow_t eo;
  wr_t ew;
  int tests = 0, fails = 0, rr = 0, pend_done = 0, n_acc = 0, n_out = 0;
  int last_idx = -1, cyc = 0, acc_cyc = 0, done_cyc = 0, w, base;
  logic [N-1:0] acc = '0, want = '0, er;
  bit idle, ov_prev = 0;
  always #5 clk = ~clk;
  contact_mem_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH), .NUM_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .drain_start(drain_start), .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe),
    .ram_addr_in(ram_addr_in), .ram_addr_out(ram_addr_out), .ram_din(ram_din), .ram_dout(ram_dout),
    .out_valid(out_valid), .out_data(out_data), .out_index(out_index), .rec_count(rec_count),
    .full(full), .busy(busy), .drain_done(drain_done)
  );
  // Contact RAM: 7-word write port, registered single-word read port.
  always @(posedge clk) begin
    if (ram_cs && ram_we)
      for (int k = 0; k < REC_WORDS; k++)
        if (int'(ram_addr_in) + k < DEPTH) mem[int'(ram_addr_in) + k] <= ram_din[k*DW +: DW];
    if (ram_cs && ram_oe) ram_dout <= (int'(ram_addr_out) < DEPTH) ? mem[int'(ram_addr_out)] : '0;
  end
  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic offer(input int i);
    for (int k = 0; k < REC_WORDS; k++) req_data[(i*REC_WORDS+k)*DW +: DW] = $urandom;
    req_valid[i] = 1'b1;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    drain_start = 1'b0;
    for (int i = 0; i < N; i++)
      if (acc[i]) begin
        acc[i] = 1'b0;
        if (want[i]) offer(i);
        else req_valid[i] = 1'b0;
      end
  endtask
  task automatic wait_idle();
    for (int t = 0; t < 100 && (busy || ram_we); t++) step();
    chk("idle_timeout", 256'(busy || ram_we), 256'(0));
  endtask
  // Monitor / scoreboard: record-level model of what the controller must present.
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      idle = !busy && !ram_we;
      if (idle && pend_done == 0) begin
        chk("rec_count", 256'(rec_count), 256'(store.size() / REC_WORDS));
        chk("full", 256'(full), 256'((store.size() / REC_WORDS) >= MAXR));
      end
      if (!idle) chk("ready_blocked", 256'(req_ready), 256'(0));
      if (busy && ov_prev) chk("out_gap", 256'(out_valid), 256'(1));
      if (out_valid) begin
        n_out++;
        last_idx = int'(out_index);
        chk("out_pending", 256'(oq.size() != 0), 256'(1));
        if (oq.size() != 0) begin
          eo = oq.pop_front();
          chk("out_index", 256'(out_index), 256'(eo.idx));
          chk("out_data", 256'(out_data), 256'(eo.data));
        end
      end
      ov_prev = out_valid;
      if (drain_done) begin
        chk("done_expected", 256'(pend_done > 0), 256'(1));
        chk("done_all_words", 256'(oq.size()), 256'(0));
        if (pend_done > 0) pend_done--;
        done_cyc = cyc;
      end
      if (ram_we) begin
        chk("write_expected", 256'(wq.size() != 0 && ram_cs), 256'(1));
        if (wq.size() != 0) begin
          ew = wq.pop_front();
          chk("write_addr", 256'(ram_addr_in), 256'(ew.addr));
          chk("write_data", 256'(ram_din), 256'(ew.din));
        end
      end
      if (idle) begin
        if (drain_start) begin
          chk("drain_wins", 256'(req_ready), 256'(0));
          for (int k = 0; k < store.size(); k++) oq.push_back('{idx: 32'(k), data: store[k]});
          store.delete();
          pend_done++;
        end else begin
          w = -1;
          for (int k = 0; k < N; k++) if (w < 0 && req_valid[(rr + k) % N]) w = (rr + k) % N;
          er = (w >= 0 && store.size() / REC_WORDS < MAXR) ? N'(1) << w : '0;
          chk("req_ready", 256'(req_ready), 256'(er));
          if (er != '0) begin
            wq.push_back('{addr: 32'(store.size()), din: req_data[w*RW +: RW]});
            for (int k = 0; k < REC_WORDS; k++) store.push_back(req_data[(w*REC_WORDS+k)*DW +: DW]);
            rr = (w + 1) % N;
            n_acc++;
            acc_cyc = cyc;
          end
          acc |= req_ready & req_valid;
        end
      end
    end
  end
  initial begin
    #300000;
    fails++;
    $display("FAIL watchdog: simulation did not finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctrl", 256'({ram_cs, ram_we, ram_oe, out_valid, drain_done, busy}), 256'(0));
    chk("rst_addr", 256'({ram_addr_in, ram_addr_out, out_index}), 256'(0));
    chk("rst_ready", 256'(req_ready), 256'(0));
    chk("rst_count", 256'(rec_count), 256'(0));
    chk("rst_full", 256'(full), 256'(DEPTH < REC_WORDS));
    rst_n = 1;
    step();
    for (int k = 0; k < REC_WORDS; k++) req_data[k*DW +: DW] = 32'h10 + 32'(k);
    req_valid = 2'b01;
    for (int t = 0; t < 20 && n_acc < 1; t++) step();
    chk("t1_accept", 256'(n_acc), 256'(1));
    chk("t1_write", 256'({ram_we, ram_addr_in}), 256'({1'b1, 32'd0}));
    step();
    chk("t1_rec_count", 256'(rec_count), 256'(1));
    want = 2'b11;
    offer(0);
    offer(1);
    for (int t = 0; t < 100 && n_acc < MAXR; t++) step();
    repeat (4) step();
    chk("t2_full", 256'({full, rec_count}), 256'({1'b1, 4'd4}));
    chk("t2_stalled", 256'(req_ready), 256'(0));
    want = '0;
    req_valid = '0;
    n_out = 0;
    drain_start = 1;
    step();
    chk("t3_busy", 256'(busy), 256'(1));
    for (int t = 0; t < 100 && pend_done > 0; t++) step();
    chk("t3_done_timeout", 256'(pend_done), 256'(0));
    step();
    chk("t3_words", 256'(n_out), 256'(MAXR * REC_WORDS));
    chk("t3_cleared", 256'({rec_count, full, busy}), 256'(0));
    drain_start = 1;
    step();
    chk("t4_done", 256'({drain_done, busy, ram_cs}), 256'({1'b1, 1'b0, 1'b0}));
    step();
    chk("t4_pulse", 256'(drain_done), 256'(0));
    base = n_acc;
    want[0] = 1;
    offer(0);
    for (int t = 0; t < 50 && n_acc < base + 2; t++) step();
    want = '0;
    req_valid = '0;
    acc = '0;
    wait_idle();
    base = n_acc;
    offer(1);
    drain_start = 1;
    step();
    chk("t5_drain_first", 256'({busy, req_ready}), 256'({1'b1, 2'b00}));
    for (int t = 0; t < 100 && n_acc == base; t++) step();
    chk("t5_accepted", 256'(n_acc), 256'(base + 1));
    chk("t5_after_done", 256'(acc_cyc >= done_cyc), 256'(1));
    chk("t5_addr", 256'({ram_we, ram_addr_in}), 256'({1'b1, 32'd0}));
    want[0] = 1;
    offer(0);
    for (int t = 0; t < 50 && store.size() < 2 * REC_WORDS; t++) step();
    want = '0;
    req_valid = '0;
    acc = '0;
    wait_idle();
    last_idx = -1;
    drain_start = 1;
    step();
    for (int t = 0; t < 100 && last_idx < 10; t++) step();
    chk("t6_reached_10", 256'(last_idx), 256'(10));
    #2 rst_n = 0;
    #1;
    chk("t6_async_clear", 256'({ram_cs, ram_oe, out_valid, busy, drain_done, rec_count}), 256'(0));
    store.delete();
    oq.delete();
    wq.delete();
    pend_done = 0;
    rr = 0;
    ov_prev = 0;
    acc = '0;
    repeat (3) step();
    rst_n = 1;
    base = n_acc;
    offer(0);
    for (int t = 0; t < 20 && n_acc == base; t++) step();
    chk("t6_addr0", 256'({ram_we, ram_addr_in}), 256'({1'b1, 32'd0}));
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) if (!req_valid[i] && $urandom_range(3) == 0) offer(i);
      if ($urandom_range(15) == 0) drain_start = 1;
      step();
    end
    req_valid = '0;
    acc = '0;
    step();
    wait_idle();
    drain_start = 1;
    step();
    for (int t = 0; t < 100 && pend_done > 0; t++) step();
    step();
    chk("final_done", 256'({pend_done, oq.size()}), 256'(0));
    chk("final_count", 256'(rec_count), 256'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
